svc_vga_stream_tx: RTL and testbench

Pixel-clock-domain VGA scan-out engine. It generates parameterised raster timing and pulls one pixel per active position from a valid/ready pixel stream. It also detects underflow and frame misalignment, and can re-lock to the stream at the next frame boundary. It sits between the framebuffer read path (after the clock-domain-crossing FIFO) and the VGA pins. It supersedes the fixed-mode, error-only VGA output stage.

---
 rtl/svc_vga_pkg.sv | 14 +
 rtl/svc_vga_timing.sv | 68 ++++++
 rtl/svc_vga_stream_tx.sv | 134 +++++++++++++
 tb/tb_svc_vga_stream_tx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/svc_vga_pkg.sv
// Shared state type and raster-total helper for the VGA stream transmitter.
package svc_vga_pkg;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } vga_state_e;

  function automatic int unsigned vga_total(input int unsigned visible, input int unsigned front,
                                            input int unsigned sync_w, input int unsigned back);
    return visible + front + sync_w + back;
  endfunction

endpackage

// File: rtl/svc_vga_timing.sv
// Raster h/v counters with active, at00 and polarity-applied sync decode.
// Outputs are combinational from the counter registers; no backpressure, free-running.
module svc_vga_timing
  import svc_vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input  logic pixel_clk,
  input  logic rst_n,
  output logic active_o,
  output logic at00_o,
  output logic hsync_o,
  output logic vsync_o
);

  localparam int unsigned H_WHOLE = vga_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_WHOLE = vga_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int unsigned HW = $clog2(H_WHOLE + 1);
  localparam int unsigned VW = $clog2(V_WHOLE + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_WHOLE - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_END = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_WHOLE - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_END = VW'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  always_comb begin
    active_o = (h_q < H_ACT) && (v_q < V_ACT);
    at00_o   = (h_q == '0) && (v_q == '0);
    hsync_o  = ((h_q >= HS_BEG) && (h_q < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_o  = ((v_q >= VS_BEG) && (v_q < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
  end

endmodule

// File: rtl/svc_vga_stream_tx.sv
// VGA scan-out from a valid/ready pixel stream; 1 cycle handshake-to-pin, s_ready only in active area
// (SYNC drains non-SOF pixels anywhere). Define SVC_VGA_RESYNC_EN to drop to SYNC and re-lock on errors.
module svc_vga_stream_tx
  import svc_vga_pkg::*;
#(
  parameter int unsigned COLOR_WIDTH   = 4,
  parameter int unsigned H_VISIBLE     = 640,
  parameter int unsigned H_FRONT       = 16,
  parameter int unsigned H_SYNC        = 96,
  parameter int unsigned H_BACK        = 48,
  parameter int unsigned V_VISIBLE     = 480,
  parameter int unsigned V_FRONT       = 10,
  parameter int unsigned V_SYNC        = 2,
  parameter int unsigned V_BACK        = 33,
  parameter bit          HSYNC_POL     = 1'b0,
  parameter bit          VSYNC_POL     = 1'b0,
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input  logic                     pixel_clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     s_sof,
  input  logic [3*COLOR_WIDTH-1:0] s_pixel,
  output logic [COLOR_WIDTH-1:0]   vga_red,
  output logic [COLOR_WIDTH-1:0]   vga_grn,
  output logic [COLOR_WIDTH-1:0]   vga_blu,
  output logic                     vga_hsync,
  output logic                     vga_vsync,
  output logic                     vga_error,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic                     locked,
  output logic                     frame_start
);

  logic active, at00, hsync_raw, vsync_raw;

  vga_state_e               state_q, state_d;
  logic                     show, err_d;
  logic [3*COLOR_WIDTH-1:0] rgb_q, rgb_d;
  logic                     hsync_q, vsync_q, err_q, fs_q;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  svc_vga_timing #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .HSYNC_POL(HSYNC_POL), .VSYNC_POL(VSYNC_POL)
  ) u_timing (
    .pixel_clk(pixel_clk),
    .rst_n    (rst_n),
    .active_o (active),
    .at00_o   (at00),
    .hsync_o  (hsync_raw),
    .vsync_o  (vsync_raw)
  );

  // Underflow and SOF/position mismatch fold into a single error event per cycle.
  always_comb begin
    state_d = state_q;
    show    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      SYNC: begin
        if (at00 && s_valid && s_sof) begin
          show    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (active) begin
          if (!s_valid || (s_sof != at00)) begin
            err_d = 1'b1;
`ifdef SVC_VGA_RESYNC_EN
            state_d = SYNC;
`else
            show = s_valid;
`endif
          end else begin
            show = 1'b1;
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_comb begin
    s_ready = s_valid && (!s_sof || at00);
    if (state_q == RUN) begin
`ifdef SVC_VGA_RESYNC_EN
      // A misplaced SOF pixel is left in the stream so it can start the next frame.
      s_ready = active && !(s_valid && s_sof && !at00);
`else
      s_ready = active;
`endif
    end
  end

  always_comb begin
    rgb_d     = show ? s_pixel : '0;
    err_cnt_d = (err_d && (err_cnt_q != '1)) ? err_cnt_q + 1'b1 : err_cnt_q;
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      state_q   <= SYNC;
      rgb_q     <= '0;
      hsync_q   <= ~HSYNC_POL;
      vsync_q   <= ~VSYNC_POL;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rgb_q     <= rgb_d;
      hsync_q   <= hsync_raw;
      vsync_q   <= vsync_raw;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      fs_q      <= at00;
    end
  end

  assign vga_red     = rgb_q[3*COLOR_WIDTH-1 -: COLOR_WIDTH];
  assign vga_grn     = rgb_q[2*COLOR_WIDTH-1 -: COLOR_WIDTH];
  assign vga_blu     = rgb_q[COLOR_WIDTH-1:0];
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign vga_error   = err_q;
  assign err_cnt     = err_cnt_q;
  assign locked      = (state_q == RUN);
  assign frame_start = fs_q;

endmodule

// File: tb/tb_svc_vga_stream_tx.sv
// Scoreboard bench for svc_vga_stream_tx on a 12x7 raster (8x4 visible) with a 2-bit error counter.
module tb_svc_vga_stream_tx;

  logic        pixel_clk = 1'b0;
  logic        rst_n     = 1'b0;
  logic        s_valid   = 1'b0;
  logic        s_ready;
  logic        s_sof     = 1'b0;
  logic [11:0] s_pixel   = '0;
  logic [3:0]  vga_red, vga_grn, vga_blu;
  logic        vga_hsync, vga_vsync, vga_error, locked, frame_start;
  logic [1:0]  err_cnt;

  always #5 pixel_clk = ~pixel_clk;

  svc_vga_stream_tx #(
    .COLOR_WIDTH(4),
    .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .ERR_CNT_WIDTH(2)
  ) dut (
    .pixel_clk  (pixel_clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_sof      (s_sof),
    .s_pixel    (s_pixel),
    .vga_red    (vga_red),
    .vga_grn    (vga_grn),
    .vga_blu    (vga_blu),
    .vga_hsync  (vga_hsync),
    .vga_vsync  (vga_vsync),
    .vga_error  (vga_error),
    .err_cnt    (err_cnt),
    .locked     (locked),
    .frame_start(frame_start)
  );

  typedef struct {
    bit          gap;
    bit          sof;
    logic [11:0] pix;
  } item_t;

  typedef struct {
    int          due;
    logic [11:0] rgb;
    bit          hs, vs, err, lk, fs;
    logic [1:0]  ecnt;
  } exp_t;

  item_t       src_q[$];
  exp_t        exp_q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          err_pulses = 0;
  logic [11:0] pix_n = 12'h001;
  bit          lk_m = 1'b0;
  logic [1:0]  ecnt_m = 2'd0;

  always @(posedge pixel_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares pins against the record scheduled for this cycle.
  always @(negedge pixel_clk) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      mon_e = exp_q.pop_front();
      chk("rgb", {20'd0, vga_red, vga_grn, vga_blu}, {20'd0, mon_e.rgb});
      chk("hsync", {31'd0, vga_hsync}, {31'd0, mon_e.hs});
      chk("vsync", {31'd0, vga_vsync}, {31'd0, mon_e.vs});
      chk("vga_error", {31'd0, vga_error}, {31'd0, mon_e.err});
      chk("err_cnt", {30'd0, err_cnt}, {30'd0, mon_e.ecnt});
      chk("locked", {31'd0, locked}, {31'd0, mon_e.lk});
      chk("frame_start", {31'd0, frame_start}, {31'd0, mon_e.fs});
      if (vga_error === 1'b1) err_pulses++;
    end
  end

  task automatic push_pix(input bit sof);
    src_q.push_back('{gap: 1'b0, sof: sof, pix: pix_n});
    pix_n++;
  endtask

  task automatic push_frame(input int gap_at);
    for (int i = 0; i < 32; i++) begin
      if (i == gap_at) src_q.push_back('{gap: 1'b1, sof: 1'b0, pix: 12'h000});
      else push_pix(i == 0);
    end
  endtask

  task automatic do_reset();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      @(posedge pixel_clk);
      #1;
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_sof   = 1'b0;
      s_pixel = '0;
      e = '{due: cyc + 1, rgb: 12'h000, hs: 1'b1, vs: 1'b1, err: 1'b0, lk: 1'b0, fs: 1'b0,
            ecnt: 2'd0};
      exp_q.push_back(e);
      if (i > 0) begin
        #1 chk("reset_s_ready", {31'd0, s_ready}, 32'd0);
      end
    end
    lk_m   = 1'b0;
    ecnt_m = 2'd0;
    src_q.delete();
  endtask

  // Drives one raster position and schedules the pins expected one cycle later.
  task automatic drive_cycle(input int h, input int v);
    item_t       it;
    exp_t        e;
    bit          have, valid, sof, at00, act, rdy, show, err;
    logic [11:0] pix;
    it    = '{gap: 1'b0, sof: 1'b0, pix: 12'h000};
    have  = (src_q.size() > 0);
    if (have) it = src_q[0];
    valid = have && !it.gap;
    sof   = valid && it.sof;
    pix   = valid ? it.pix : 12'h000;
    rst_n   = 1'b1;
    s_valid = valid;
    s_sof   = sof;
    s_pixel = pix;
    at00 = (h == 0) && (v == 0);
    act  = (h < 8) && (v < 4);
    show = 1'b0;
    err  = 1'b0;
    if (!lk_m) begin
      rdy = valid && (!sof || at00);
      if (valid && sof && at00) begin
        show = 1'b1;
        lk_m = 1'b1;
      end
    end else begin
`ifdef SVC_VGA_RESYNC_EN
      rdy = act && !(valid && sof && !at00);
`else
      rdy = act;
`endif
      if (act) begin
        err = !valid || (sof != at00);
`ifdef SVC_VGA_RESYNC_EN
        show = valid && !err;
        if (err) lk_m = 1'b0;
`else
        show = valid;
`endif
      end
    end
    #1 chk("s_ready", {31'd0, s_ready}, {31'd0, rdy});
    if (have && (it.gap || (valid && rdy))) void'(src_q.pop_front());
    if (err && ecnt_m != 2'd3) ecnt_m = ecnt_m + 2'd1;
    e = '{due: cyc + 1, rgb: show ? pix : 12'h000, hs: !(h == 9 || h == 10), vs: (v != 5),
          err: err, lk: lk_m, fs: at00, ecnt: ecnt_m};
    exp_q.push_back(e);
  endtask

  task automatic run_frames(input int nf);
    for (int k = 0; k < nf * 84; k++) begin
      @(posedge pixel_clk);
      #1;
      drive_cycle(k % 12, (k / 12) % 7);
    end
    @(negedge pixel_clk);
  endtask

  initial begin
    // Reset followed by three clean frames.
    do_reset();
    push_frame(-1);
    push_frame(-1);
    push_frame(-1);
    run_frames(3);
    chk("clean_err_cnt", {30'd0, err_cnt}, 32'd0);
    chk("clean_locked", {31'd0, locked}, 32'd1);
    chk("clean_src_empty", src_q.size(), 32'd0);

    // Five stray pixels are drained, then lock on the SOF frame.
    do_reset();
    for (int i = 0; i < 5; i++) push_pix(1'b0);
    push_frame(-1);
    run_frames(2);
    chk("drain_err_cnt", {30'd0, err_cnt}, 32'd0);
    chk("drain_locked", {31'd0, locked}, 32'd1);

    // Underflow at (3,1).
    do_reset();
    push_frame(11);
    push_frame(-1);
    run_frames(2);
    chk("underflow_err_cnt", {30'd0, err_cnt}, 32'd1);
    chk("underflow_locked", {31'd0, locked}, 32'd1);

    // SOF presented at (5,2).
    do_reset();
    for (int i = 0; i < 21; i++) push_pix(i == 0);
    push_pix(1'b1);
`ifdef SVC_VGA_RESYNC_EN
    for (int i = 1; i < 32; i++) push_pix(1'b0);
`else
    for (int i = 22; i < 32; i++) push_pix(1'b0);
    push_frame(-1);
`endif
    run_frames(2);
    chk("misalign_err_cnt", {30'd0, err_cnt}, 32'd1);
    chk("misalign_src_empty", src_q.size(), 32'd0);

    // Five underflows against a 2-bit counter.
    do_reset();
    err_pulses = 0;
    for (int f = 0; f < 5; f++) push_frame(11);
    run_frames(5);
    chk("sat_err_cnt", {30'd0, err_cnt}, 32'd3);
    chk("sat_pulses", err_pulses, 32'd5);

    repeat (2) @(posedge pixel_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
